icache: RTL
===========

# icache

Direct-mapped, read-only instruction cache between the fetch stage's PC and a slow word-wide instruction memory. A hit returns the instruction combinationally in the same cycle. A miss holds `StallF_o` high while a refill FSM fetches the whole line one word per beat. While stalled, `Instr_o` carries a NOP so the F/D register can capture a bubble. `Flush_i` (fence.i / reprogramming) invalidates every line.

## Interface
- `DATA_WIDTH`, 32, instruction/word width
- `ADDR_WIDTH`, 32, byte address width
- `LINES`, 16, number of lines (power of 2)
- `WORDS_PER_LINE`, 4, words per line (power of 2, ≥2)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `PCF_i`  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
- `ReqF_i`  in  1  fetch request valid this cycle
- `Flush_i`  in  1  invalidate all lines at next edge
- `Instr_o`  out  DATA_WIDTH  instruction for `PCF_i`; 32'h00000013 when `StallF_o`=1
- `StallF_o`  out  1  instruction not available; fetch must hold PC and F/D must insert a bubble
- `MemReq_o`  out  1  refill in progress
- `MemAddr_o`  out  ADDR_WIDTH  byte address of the word currently requested
- `MemRData_i`  in  DATA_WIDTH  word returned for `MemAddr_o`
- `MemValid_i`  in  1  `MemRData_i` valid for the current `MemAddr_o` (beat accepted)

## Operation
- Address split for the defaults, word offset first:
  - offset = `PCF_i`[3:2]
  - index = [7:4]
  - tag = [31:8]
  - Widths follow from the parameters via $clog2.
- Storage per line: valid bit, tag, WORDS_PER_LINE data words. Data arrays are plain registers with no reset; valid bits reset to 0.
- Hit = `ReqF_i` & valid[index] & (tag[index] == tag) & state IDLE.
- `StallF_o` = `ReqF_i` & ~hit. With `ReqF_i`=0: `StallF_o`=0 and `Instr_o`=NOP.
- FSM states:
  - **IDLE**
    - On `ReqF_i` & ~hit & ~`Flush_i`: latch line base address (offset zeroed), clear beat counter, go to REFILL.
    - On `ReqF_i` & ~hit & `Flush_i`: the flush wins and the miss is retried next cycle.
  - **REFILL**
    - `MemReq_o`=1 and `MemAddr_o` = base + 4*beat.
    - Each cycle with `MemValid_i`=1: write `MemRData_i` into data[index][beat] and increment beat.
    - On the last beat: write tag, set valid (unless poisoned), go to IDLE.
    - Gaps (`MemValid_i`=0) are allowed and hold the state.
- `MemReq_o`=0 and `MemAddr_o`=0 in IDLE.
- PC change during REFILL (branch redirect): the refill completes for the latched line. `StallF_o` is computed against the current `PCF_i`, so a redirect to a line already resident still stalls until IDLE, then hits.
- `Flush_i`:
  - In IDLE: all valid bits are cleared at the edge.
  - In REFILL: all valid bits are cleared and a poison flag is set. The remaining beats are still consumed because the memory cannot cancel, but the line is not validated. The poison flag clears on return to IDLE.
- Refill of a line evicts the previous occupant of that index. Its valid bit is cleared on REFILL entry, so a partially written line is never hit.

## Timing
- Reset (`rst`=0, async): state IDLE, all valid = 0, beat = 0, poison = 0, `MemReq_o`=0, `MemAddr_o`=0. `StallF_o`/`Instr_o` are combinational and therefore equal 1/NOP if `ReqF_i`=1.
- Reset asserted mid-refill: the refill is abandoned immediately and `MemReq_o` drops asynchronously.
- Hit latency: 0 cycles (combinational from `PCF_i`).
- Miss with a zero-wait memory (`MemValid_i` high every REFILL cycle):
  - miss detected in cycle 0
  - REFILL in cycles 1..WORDS_PER_LINE
  - hit in cycle WORDS_PER_LINE+1
  - total stall = WORDS_PER_LINE+1 cycles (5 at defaults)
- Each wait cycle from memory adds exactly one stall cycle.
- `MemAddr_o` changes only on the edge after an accepted beat. `MemReq_o` falls on the edge that accepts the last beat.

## Test plan
- **Cold miss then hits:** reset, `ReqF_i`=1, `PCF_i`=0x00 with memory word[n]=0x1000+n, zero-wait.
  - `StallF_o`=1 for cycles 0–4.
  - `MemAddr_o` = 0x0, 0x4, 0x8, 0xC in cycles 1–4.
  - Cycle 5: `Instr_o`=0x1000, `StallF_o`=0.
  - PC 0x4/0x8/0xC then hit with 0x1001/0x1002/0x1003.
- **Conflict eviction:** fill 0x000, then fetch 0x100 (same index, different tag) → refill. Refetching 0x000 misses again.
- **Wait states:** `MemValid_i` pattern 1,0,0,1,1,0,1 → exactly 7 REFILL cycles. Data lands in the correct words and `MemAddr_o` holds during gaps.
- **Redirect during refill:** miss on 0x40, change `PCF_i` to 0x00 (resident) at REFILL cycle 2.
  - `StallF_o` stays 1 until REFILL ends.
  - Next cycle: hit on 0x00, and line 0x40 is valid.
- **Flush:**
  - `Flush_i` in IDLE after filling 0x00 → the next fetch of 0x00 misses.
  - `Flush_i` in REFILL beat 1 → all 4 beats consumed, and the same PC then misses again.
- **Async reset mid-refill:** pull `rst` low at beat 2 → `MemReq_o`=0 immediately. After release the previously filled line misses.

Source files
------------

// File: rtl/icache_if.sv
// Fetch-side and refill-memory signals of the instruction cache.
// slave is the cache; master drives PC, flush and memory returns.
interface icache_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] PCF_i;
  logic                  ReqF_i;
  logic                  Flush_i;
  logic [DATA_WIDTH-1:0] Instr_o;
  logic                  StallF_o;
  logic                  MemReq_o;
  logic [ADDR_WIDTH-1:0] MemAddr_o;
  logic [DATA_WIDTH-1:0] MemRData_i;
  logic                  MemValid_i;

  modport master (
    output PCF_i, ReqF_i, Flush_i,
    output MemRData_i, MemValid_i,
    input  Instr_o, StallF_o,
    input  MemReq_o, MemAddr_o
  );

  modport slave (
    input  PCF_i, ReqF_i, Flush_i,
    input  MemRData_i, MemValid_i,
    output Instr_o, StallF_o,
    output MemReq_o, MemAddr_o
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache with
// combinational hit path and word-per-beat refill FSM.
module icache #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input logic   clk,
  input logic   rst,
  icache_if.slave bus
);
  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(LINES);
  localparam int LW = ADDR_WIDTH - OW - 2;
  localparam int TW = LW - IW;
  localparam logic [DATA_WIDTH-1:0] NOP = 32'h00000013;
  localparam logic [OW-1:0] LAST = OW'(WORDS_PER_LINE - 1);

  typedef enum logic {IDLE, REFILL} state_e;

  state_e                state_q;
  logic [LINES-1:0]      valid_q;
  logic [TW-1:0]         tag_q [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES][WORDS_PER_LINE];
  logic [OW-1:0]         beat_q;
  logic [LW-1:0]         line_q;
  logic                  poison_q;
  logic                  req_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic [OW-1:0] off;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [LW-1:0] line;
  logic [IW-1:0] lidx;
  logic [TW-1:0] ltag;
  logic          hit;
  logic          miss;
  logic          last;
  logic          beat_wr;
  logic          unused;

  assign line = bus.PCF_i[ADDR_WIDTH-1:OW+2];
  assign off  = bus.PCF_i[OW+1:2];
  assign idx  = line[IW-1:0];
  assign tag  = line[LW-1:IW];
  assign lidx = line_q[IW-1:0];
  assign ltag = line_q[LW-1:IW];
  assign unused = ^bus.PCF_i[1:0];

  assign hit = bus.ReqF_i & valid_q[idx]
             & (tag_q[idx] == tag)
             & (state_q == IDLE);
  assign miss    = bus.ReqF_i & ~hit;
  assign last    = (beat_q == LAST);
  assign beat_wr = (state_q == REFILL) & bus.MemValid_i;

  assign bus.StallF_o  = miss;
  assign bus.Instr_o   = hit ? data_q[idx][off] : NOP;
  assign bus.MemReq_o  = req_q;
  assign bus.MemAddr_o = addr_q;

  // Line storage carries no reset; valid_q alone guards it.
  always_ff @(posedge clk) begin
    if (beat_wr) begin
      data_q[lidx][beat_q] <= bus.MemRData_i;
      if (last) tag_q[lidx] <= ltag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      valid_q  <= '0;
      beat_q   <= '0;
      line_q   <= '0;
      poison_q <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.Flush_i) begin
            valid_q <= '0;
          end else if (miss) begin
            line_q       <= line;
            beat_q       <= '0;
            valid_q[idx] <= 1'b0;
            req_q        <= 1'b1;
            addr_q       <= {line, {(OW+2){1'b0}}};
            state_q      <= REFILL;
          end
        end
        REFILL: begin
          // Memory cannot cancel, so a flushed refill runs to the end
          if (bus.Flush_i) begin
            valid_q  <= '0;
            poison_q <= 1'b1;
          end
          if (bus.MemValid_i) begin
            if (last) begin
              if (!(poison_q | bus.Flush_i)) valid_q[lidx] <= 1'b1;
              poison_q <= 1'b0;
              beat_q   <= '0;
              req_q    <= 1'b0;
              addr_q   <= '0;
              state_q  <= IDLE;
            end else begin
              beat_q <= beat_q + 1'b1;
              addr_q <= addr_q + ADDR_WIDTH'(4);
            end
          end
        end
      endcase
    end
  end
endmodule
